// File: rtl/dac_realtime_uart.sv
// dac_realtime_uart: UART-fed 12-bit sample player driving a PmodDA2 (both channels, same word).
// Latency: playing/fifo_level update 1 cycle after the rx byte; sync_n falls 1 cycle after a playback tick.
// Backpressure: none upstream (UART); samples arriving on a full FIFO are dropped and counted.
// Ports: clk/rst (async, active-high); uart_rx (idle high); da_sync_n/da_sclk/da_d0/da_d1 DAC serial bus;
//        playing, current_dac_data, fifo_level, underrun_count, overflow_count status.

// rx: 8N1 UART byte receiver, one clk domain, DIV clk cycles per bit.
// Latency: valid pulses mid-stop-bit, about 9.5 bit periods after the start edge.
// Backpressure: none; valid is a one-cycle pulse, err flags a missing stop bit.
module rx #(
  parameter int DIV = 542
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_line,
  output logic [7:0] data,
  output logic       valid,
  output logic       err
);
  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    sh;
  logic          rx_s1, rx_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      sh      <= '0;
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      data    <= '0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      rx_s1 <= rx_line;
      rx_s2 <= rx_s1;
      valid <= 1'b0;
      err   <= 1'b0;
      case (state)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_s2) state <= RX_START;
        end
        RX_START: begin
          // Re-check the start bit at its centre to reject glitches.
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            sh      <= {rx_s2, sh[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            data  <= sh;
            valid <= 1'b1;
            err   <= !rx_s2;
            state <= RX_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end
endmodule

module dac_realtime_uart #(
  parameter int DIV_RATIO       = 542,
  parameter int SAMPLE_INTERVAL = 12500,
  parameter int SCLK_HALF       = 4,
  parameter int FIFO_AW         = 4,
  parameter int RESYNC_TIMEOUT  = 54200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               uart_rx,
  output logic               da_sync_n,
  output logic               da_sclk,
  output logic               da_d0,
  output logic               da_d1,
  output logic               playing,
  output logic [11:0]        current_dac_data,
  output logic [FIFO_AW:0]   fifo_level,
  output logic [15:0]        underrun_count,
  output logic [15:0]        overflow_count
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(SAMPLE_INTERVAL);
  localparam int RW    = $clog2(RESYNC_TIMEOUT);
  localparam int HW    = $clog2(2 * SCLK_HALF);
  localparam logic [TW-1:0]      TIMER_LAST  = TW'(SAMPLE_INTERVAL - 1);
  localparam logic [RW-1:0]      RESYNC_LAST = RW'(RESYNC_TIMEOUT - 1);
  localparam logic [HW-1:0]      HALF_LAST   = HW'(SCLK_HALF - 1);
  localparam logic [HW-1:0]      GAP_LAST    = HW'(2 * SCLK_HALF - 1);
  localparam logic [FIFO_AW:0]   LEVEL_FULL  = (FIFO_AW + 1)'(DEPTH);

  // ---------------- byte receive ----------------
  logic [7:0] rx_data;
  logic       rx_vld, rx_err;

  rx #(.DIV(DIV_RATIO)) u_rx (
    .clk    (clk),
    .rst    (rst),
    .rx_line(uart_rx),
    .data   (rx_data),
    .valid  (rx_vld),
    .err    (rx_err)
  );

  logic              phase;       // 0: expect high byte / command, 1: expect low byte
  logic [3:0]        hi_nib;
  logic [RW-1:0]     resync_cnt;
  logic [TW-1:0]     timer;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [11:0]       mem [DEPTH];
  logic [11:0]       fifo_rd;

  logic byte_ok, lo_byte, start_cmd, stop_cmd;
  logic fifo_empty, fifo_full, tick, pop, push, underrun_inc, overflow_inc;

  assign byte_ok   = rx_vld && !rx_err;
  assign lo_byte   = byte_ok && phase;
  assign start_cmd = byte_ok && !phase && (rx_data == 8'h53);
  assign stop_cmd  = byte_ok && !phase && (rx_data == 8'h73);

  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LEVEL_FULL);
  assign fifo_rd    = mem[rd_ptr];

  // Stop beats a coincident tick; a restart in the wrap cycle also suppresses it.
  assign tick         = playing && (timer == TIMER_LAST) && !stop_cmd && !start_cmd;
  assign pop          = tick && !fifo_empty;
  assign underrun_inc = tick && fifo_empty;
  // A simultaneous pop frees a slot, so a full FIFO still accepts the push.
  assign push         = lo_byte && (!fifo_full || pop);
  assign overflow_inc = lo_byte && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {hi_nib, rx_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase            <= 1'b0;
      hi_nib           <= '0;
      resync_cnt       <= '0;
      playing          <= 1'b0;
      timer            <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      fifo_level       <= '0;
      current_dac_data <= '0;
      underrun_count   <= '0;
      overflow_count   <= '0;
    end else begin
      // Byte framing; a stalled low byte times out and the partial sample is dropped.
      if (byte_ok) begin
        resync_cnt <= '0;
        if (phase) begin
          phase <= 1'b0;
        end else if (rx_data[7:4] == 4'h0) begin
          phase  <= 1'b1;
          hi_nib <= rx_data[3:0];
        end
      end else if (phase) begin
        if (resync_cnt == RESYNC_LAST) begin
          phase      <= 1'b0;
          resync_cnt <= '0;
        end else begin
          resync_cnt <= resync_cnt + RW'(1);
        end
      end

      // Playback control and sample timer.
      if (stop_cmd) begin
        playing <= 1'b0;
        timer   <= '0;
      end else if (start_cmd) begin
        playing <= 1'b1;
        timer   <= '0;
        if (!playing) begin
          underrun_count <= '0;
          overflow_count <= '0;
        end
      end else if (playing) begin
        timer <= (timer == TIMER_LAST) ? '0 : timer + TW'(1);
      end

      if (underrun_inc && underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
      if (overflow_inc && overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'd1;

      // FIFO bookkeeping; stop flushes by snapping the read pointer to the write pointer.
      if (stop_cmd) begin
        rd_ptr     <= wr_ptr;
        fifo_level <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
        if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
        if (push && !pop)      fifo_level <= fifo_level + (FIFO_AW + 1)'(1);
        else if (pop && !push) fifo_level <= fifo_level - (FIFO_AW + 1)'(1);
      end
      if (pop) current_dac_data <= fifo_rd;
    end
  end

  // ---------------- DAC serial frame ----------------
  typedef enum logic [1:0] {SPI_IDLE, SPI_SHIFT, SPI_GAP} spi_state_t;

  spi_state_t    spi_state;
  logic [15:0]   spi_sh;
  logic [15:0]   frame_word;
  logic [HW-1:0] half_cnt;
  logic [3:0]    bit_cnt;
  logic          spi_d;

  assign frame_word = {4'b0000, fifo_rd};
  assign da_d0      = spi_d;
  assign da_d1      = spi_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_state <= SPI_IDLE;
      da_sync_n <= 1'b1;
      da_sclk   <= 1'b1;
      spi_d     <= 1'b0;
      spi_sh    <= '0;
      half_cnt  <= '0;
      bit_cnt   <= '0;
    end else begin
      case (spi_state)
        SPI_IDLE: begin
          if (pop) begin
            // Bit 15 is on the line as sync_n falls; first sclk fall is SCLK_HALF later.
            spi_state <= SPI_SHIFT;
            da_sync_n <= 1'b0;
            da_sclk   <= 1'b1;
            spi_sh    <= frame_word;
            spi_d     <= frame_word[15];
            half_cnt  <= '0;
            bit_cnt   <= '0;
          end
        end
        SPI_SHIFT: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            if (da_sclk) begin
              da_sclk <= 1'b0;
            end else if (bit_cnt == 4'd15) begin
              spi_state <= SPI_GAP;
              da_sync_n <= 1'b1;
              da_sclk   <= 1'b1;
              spi_d     <= 1'b0;
            end else begin
              // Data advances on the rising edge, away from the DAC's falling-edge sample.
              da_sclk <= 1'b1;
              bit_cnt <= bit_cnt + 4'd1;
              spi_sh  <= {spi_sh[14:0], 1'b0};
              spi_d   <= spi_sh[14];
            end
          end else begin
            half_cnt <= half_cnt + HW'(1);
          end
        end
        SPI_GAP: begin
          if (half_cnt == GAP_LAST) begin
            half_cnt  <= '0;
            spi_state <= SPI_IDLE;
          end else begin
            half_cnt <= half_cnt + HW'(1);
          end
        end
        default: spi_state <= SPI_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dac_realtime_uart.sv
// tb_dac_realtime_uart: table-driven byte parser vectors plus scripted playback/corner sequences.
// A negedge monitor decodes DAC frames and scores them against a queue of expected samples.
// Ports of the DUT are all connected; parameters shrunk so the run stays short.
module tb_dac_realtime_uart;
  localparam int DIV = 16;
  localparam int SI  = 300;
  localparam int SH  = 4;
  localparam int AW  = 4;
  localparam int RT  = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_rx;
  logic        da_sync_n, da_sclk, da_d0, da_d1, playing;
  logic [11:0] current_dac_data;
  logic [AW:0] fifo_level;
  logic [15:0] underrun_count, overflow_count;

  dac_realtime_uart #(
    .DIV_RATIO(DIV), .SAMPLE_INTERVAL(SI), .SCLK_HALF(SH), .FIFO_AW(AW), .RESYNC_TIMEOUT(RT)
  ) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx),
    .da_sync_n(da_sync_n), .da_sclk(da_sclk), .da_d0(da_d0), .da_d1(da_d1),
    .playing(playing), .current_dac_data(current_dac_data), .fifo_level(fifo_level),
    .underrun_count(underrun_count), .overflow_count(overflow_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int frames = 0;
  int t_play = 0;
  int t_fall = 0;
  logic [11:0] exp_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
    end
  endtask

  // ---------------- frame monitor / scoreboard ----------------
  logic [15:0] mon_word;
  int          mon_bits;
  logic [11:0] mon_exp;
  logic        mon_in = 1'b0, mon_dmis = 1'b0;
  logic        prev_sync = 1'b1, prev_sclk = 1'b1, prev_play = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      mon_in    = 1'b0;
      prev_sync = 1'b1;
      prev_sclk = 1'b1;
      prev_play = 1'b0;
    end else begin
      if (!prev_play && playing) t_play = cyc;
      if (prev_sync && !da_sync_n) begin
        mon_in   = 1'b1;
        mon_bits = 0;
        mon_word = '0;
        mon_dmis = 1'b0;
        t_fall   = cyc;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          mon_exp = '0;
          $display("FAIL frame_expected: got a frame, wanted none (cycle %0d)", cyc);
        end else begin
          mon_exp = exp_q.pop_front();
          check("cur_data_at_sync", 32'(current_dac_data), 32'(mon_exp));
        end
      end
      if (mon_in && prev_sclk && !da_sclk) begin
        mon_word = {mon_word[14:0], da_d0};
        if (da_d0 !== da_d1) mon_dmis = 1'b1;
        mon_bits++;
      end
      if (mon_in && !prev_sync && da_sync_n) begin
        mon_in = 1'b0;
        check("frame_word", 32'(mon_word), {20'h0, 4'h0, mon_exp});
        check("frame_bits", 32'(mon_bits), 32'd16);
        check("frame_len", 32'(cyc - t_fall), 32'(32 * SH));
        check("d0_eq_d1", 32'(mon_dmis), 32'd0);
        frames++;
      end
      prev_sync = da_sync_n;
      prev_sclk = da_sclk;
      prev_play = playing;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      uart_rx = 1'b0;
      else if (i == 9) uart_rx = 1'b1;
      else             uart_rx = b[i-1];
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic send_sample(input logic [11:0] s);
    send_byte({4'h0, s[11:8]});
    send_byte(s[7:0]);
  endtask

  task automatic wait_frame(input int prev, input int limit, input string name);
    int n = 0;
    while (frames == prev && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(frames), 32'(prev + 1));
  endtask

  typedef struct packed {
    logic [7:0]  b;
    logic [AW:0] lvl;
    logic        play;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, wanted completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    vecs[0] = '{8'h41, 5'd0, 1'b0};  // upper nibble non-zero: ignored
    vecs[1] = '{8'h0A, 5'd0, 1'b0};  // high byte latched
    vecs[2] = '{8'hBC, 5'd1, 1'b0};  // low byte: push 0xABC
    vecs[3] = '{8'h73, 5'd0, 1'b0};  // 's' flushes even when stopped
    vecs[4] = '{8'h01, 5'd0, 1'b0};
    vecs[5] = '{8'h53, 5'd1, 1'b0};  // 'S' value taken as a low byte in phase 1
    vecs[6] = '{8'hFF, 5'd1, 1'b0};  // ignored
    vecs[7] = '{8'h02, 5'd1, 1'b0};
    vecs[8] = '{8'h34, 5'd2, 1'b0};
    vecs[9] = '{8'h73, 5'd0, 1'b0};

    rst = 1'b1;
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;

    // Reset and idle.
    repeat (1000) @(negedge clk);
    check("idle_sync_n", 32'(da_sync_n), 32'd1);
    check("idle_sclk", 32'(da_sclk), 32'd1);
    check("idle_d0", 32'(da_d0), 32'd0);
    check("idle_d1", 32'(da_d1), 32'd0);
    check("idle_playing", 32'(playing), 32'd0);
    check("idle_level", 32'(fifo_level), 32'd0);
    check("idle_cur", 32'(current_dac_data), 32'd0);
    check("idle_underrun", 32'(underrun_count), 32'd0);
    check("idle_overflow", 32'(overflow_count), 32'd0);
    check("idle_frames", 32'(frames), 32'd0);

    // Byte parser vectors.
    for (int i = 0; i < 10; i++) begin
      send_byte(vecs[i].b);
      check($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vecs[i].lvl));
      check($sformatf("vec%0d_playing", i), 32'(playing), 32'(vecs[i].play));
    end

    // Single sample then start: one frame of 0x0ABC, first tick SI cycles after start.
    exp_q.push_back(12'hABC);
    send_sample(12'hABC);
    check("c_level_pre", 32'(fifo_level), 32'd1);
    f0 = frames;
    send_byte(8'h53);
    check("c_playing", 32'(playing), 32'd1);
    wait_frame(f0, SI + 200, "c_frame_seen");
    check("c_tick_delay", 32'(t_fall - t_play), 32'(SI));
    check("c_cur", 32'(current_dac_data), 32'hABC);
    check("c_level_post", 32'(fifo_level), 32'd0);
    send_byte(8'h73);
    check("c_stopped", 32'(playing), 32'd0);

    // Start with an empty FIFO: three underruns, then a late sample plays.
    f0 = frames;
    send_byte(8'h53);
    check("d_under_clr", 32'(underrun_count), 32'd0);
    repeat (3 * SI) @(negedge clk);
    check("d_underrun3", 32'(underrun_count), 32'd3);
    check("d_no_frame", 32'(frames), 32'(f0));
    exp_q.push_back(12'hFFF);
    send_sample(12'hFFF);
    wait_frame(f0, 2 * SI + 100, "d_frame_seen");
    check("d_cur", 32'(current_dac_data), 32'hFFF);
    send_byte(8'h73);

    // Overflow: 17 samples while stopped, then stop flushes without playing anything.
    for (int i = 0; i < 17; i++) begin
      logic [11:0] s;
      s = 12'(i * 12'h0F3 + 12'h011);
      if (exp_q.size() < 16) exp_q.push_back(s);
      send_sample(s);
    end
    check("e_level_full", 32'(fifo_level), 32'd16);
    check("e_overflow", 32'(overflow_count), 32'd1);
    f0 = frames;
    send_byte(8'h73);
    exp_q.delete();
    check("e_level_flush", 32'(fifo_level), 32'd0);
    repeat (2 * SI) @(negedge clk);
    check("e_no_frame", 32'(frames), 32'(f0));

    // Resync: a lone high byte is abandoned after the idle timeout.
    send_byte(8'h05);
    repeat (RT + 10) @(negedge clk);
    exp_q.push_back(12'h123);
    send_sample(12'h123);
    check("f_level", 32'(fifo_level), 32'd1);
    f0 = frames;
    send_byte(8'h53);
    wait_frame(f0, SI + 200, "f_frame_seen");
    check("f_cur", 32'(current_dac_data), 32'h123);
    send_byte(8'h73);

    // Reset in the 8th sclk cycle of a frame.
    exp_q.push_back(12'hAA5);
    send_sample(12'hAA5);
    send_byte(8'h53);
    begin
      int n = 0;
      while (da_sync_n && n < 2 * SI) begin
        @(negedge clk);
        n++;
      end
    end
    check("g_sync_low", 32'(da_sync_n), 32'd0);
    repeat (7 * 2 * SH + 2) @(negedge clk);
    check("g_pre_rst_sync", 32'(da_sync_n), 32'd0);
    f0 = frames;
    rst = 1'b1;
    #1;
    check("g_rst_sync_n", 32'(da_sync_n), 32'd1);
    check("g_rst_sclk", 32'(da_sclk), 32'd1);
    check("g_rst_d0", 32'(da_d0), 32'd0);
    check("g_rst_playing", 32'(playing), 32'd0);
    check("g_rst_cur", 32'(current_dac_data), 32'd0);
    check("g_rst_level", 32'(fifo_level), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2 * SI) @(negedge clk);
    check("g_no_frame", 32'(frames), 32'(f0));
    check("g_post_sync", 32'(da_sync_n), 32'd1);
    check("g_post_playing", 32'(playing), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dac_realtime_uart.md
# dac_realtime_uart

Receives 12-bit samples over UART and plays them out at a fixed rate to a PmodDA2 (dual DAC121S101, SPI-like) in the ADC→UART capture path's reverse direction. Host streams big-endian 2-byte sample frames plus single-byte start/stop commands. A small FIFO absorbs UART jitter, and a sample-rate timer pops one sample per tick into a 16-bit serial frame driven to both DAC channels.

## Interface
- DIV_RATIO, 542: UART bit period in clk cycles, passed to the codebase `rx` instance (125 MHz / 230400).
- SAMPLE_INTERVAL, 12500: clk cycles between playback ticks (10 kHz).
- SCLK_HALF, 4: clk cycles per SCLK half-period (15.6 MHz SCLK). Requires 32*SCLK_HALF + 2*SCLK_HALF < SAMPLE_INTERVAL.
- FIFO_AW, 4: FIFO address width (depth 16).
- RESYNC_TIMEOUT, 54200: idle clk cycles after which the byte-phase returns to "expect high byte".
- clk  in  1  system clock, 125 MHz; the only clock.
- rst  in  1  asynchronous, active-high reset.
- uart_rx  in  1  UART line, idle high.
- da_sync_n  out  1  DAC frame sync, active low.
- da_sclk  out  1  DAC serial clock, idles high.
- da_d0  out  1  serial data, DAC channel A.
- da_d1  out  1  serial data, DAC channel B (same word as d0).
- playing  out  1  playback enabled.
- current_dac_data  out  12  last sample shifted out.
- fifo_level  out  FIFO_AW+1  FIFO occupancy, 0..2^FIFO_AW.
- underrun_count  out  16  ticks with empty FIFO while playing; saturates at 0xFFFF.
- overflow_count  out  16  samples dropped because the FIFO was full; saturates at 0xFFFF.

## Operation
- Byte receive uses the `rx` instance. Bytes with err set are discarded. Each one-cycle valid pulse carries one byte.
- Byte phase 0 (expect high byte):
  - upper nibble 0000: latch bits[3:0] as sample[11:8], go to phase 1.
  - 0x53 'S': start command.
  - 0x73 's': stop command.
  - any other byte: ignored.
- Byte phase 1: the byte is sample[7:0]. Push {hi, lo} into the FIFO, then return to phase 0.
  - Full FIFO: drop the sample and increment overflow_count.
  - Pushes are accepted whether or not playback is running (pre-fill).
- Resync: if phase 1 persists for RESYNC_TIMEOUT cycles without a valid byte, go to phase 0 and discard the partial sample.
- 'S':
  - playing<=1.
  - Sample timer cleared.
  - underrun_count and overflow_count cleared.
  - FIFO contents kept.
  - 'S' while already playing restarts the timer only.
- 's':
  - playing<=0.
  - FIFO flushed (level 0).
  - Any SPI frame in progress completes normally.
- Tick: while playing, the timer counts 0..SAMPLE_INTERVAL-1, and the tick fires on the wrap. The first tick is SAMPLE_INTERVAL cycles after the command cycle.
  - FIFO non-empty: pop, set current_dac_data, start an SPI frame.
  - FIFO empty: increment underrun_count, no frame; the DAC holds its last value.
- SPI FSM states:
  - IDLE: sync_n=1, sclk=1.
  - SHIFT: sync_n=0; 16 bits of {4'b0000, sample} sent MSB first. Data changes on sclk rising edges, and the DAC samples on falling edges. Bit 15 is presented when sync_n falls; sclk falls SCLK_HALF cycles later.
  - GAP: after the 16th falling edge plus SCLK_HALF, sync_n=1 and sclk=1 for 2*SCLK_HALF cycles, then IDLE.
  - A tick cannot occur outside IDLE, guaranteed by the parameter constraint.
- Simultaneous events:
  - Push and pop in the same cycle: both occur, and the level is unchanged. If the FIFO was full, the push is accepted.
  - Stop and tick in the same cycle: stop wins; no pop, no underrun.
  - FIFO pointers wrap modulo 2^FIFO_AW; level is tracked separately.

## Timing
- Reset values:
  - da_sync_n=1, da_sclk=1, da_d0=da_d1=0.
  - playing=0, current_dac_data=0, fifo_level=0.
  - underrun_count=0, overflow_count=0.
  - Byte phase 0, SPI FSM IDLE, FIFO empty.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronous).
- Command effect: playing changes on the cycle after the rx valid pulse.
- Push: fifo_level updates on the cycle after the low-byte valid pulse.
- Tick to sync_n falling: 1 cycle. current_dac_data and fifo_level update on the same edge.
- Frame length: 32*SCLK_HALF cycles with sync_n low, then 2*SCLK_HALF cycles of gap (136 cycles at default).

## Test plan
- Reset, then idle for 1000 cycles: sync_n=1, sclk=1, all counters 0, playing=0.
- Send 0x0A,0xBC then 'S': after 12500 cycles, one frame shifts 0x0ABC MSB-first on d0 and d1, sampled on 16 sclk falling edges; current_dac_data=0xABC; fifo_level 1→0.
- 'S' with an empty FIFO, wait 3 ticks: no sync_n activity, underrun_count=3. Then send 0x0F,0xFF: the next tick outputs 0xFFF.
- Push 17 samples without 'S': fifo_level=16, overflow_count=1. Then 's': fifo_level=0, no frame emitted.
- Send lone 0x05, wait RESYNC_TIMEOUT+10 cycles, send 0x01,0x23: FIFO holds exactly 0x123.
- Assert rst during the 8th sclk cycle of a frame: sync_n=1 and sclk=1 immediately; after release, no frame until a new 'S' and tick.
